// File: rtl/rotr_unit.sv
// ---------------------------------------------------------------------------
// rotr_unit
//   Multi-cycle right-rotator. It takes one word plus a rotate amount, rotates
//   the word right by one bit per clock, and then offers the result. It sits
//   after the rotate-left register stage and puts the original bit order back.
//
// Parameters
//   WIDTH  data width (power of two, >= 2)
//   CNT_W  amount / counter width, equal to clog2(WIDTH)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   in_valid   input word and amount valid
//   in_ready   block can accept an input (combinational from state)
//   in_data    word to rotate
//   in_amt     right-rotate amount, 0..WIDTH-1
//   out_valid  result valid (held while in DONE)
//   out_ready  consumer takes the result
//   out_data   rotated word (the shift register itself)
//   busy       high while rotating
//
// Build option
//   ROTR_BACK2BACK_EN  when defined, DONE accepts a new word on the same edge
//                      that the result leaves (in_ready follows out_ready).
//                      When undefined, every result passes through IDLE.
// ---------------------------------------------------------------------------

// One bit of the rotate register: load, rotate-in from the upper neighbour,
// or hold.
module rotr_cell (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic ld_bit,
    input  logic sh_bit,
    output logic q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     q <= 1'b0;
        else if (load)  q <= ld_bit;
        else if (shift) q <= sh_bit;
    end
endmodule

module rotr_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // An accepted request, kept together so the load path reads as one thing.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] amt;
    } req_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] sr;
    req_t             req;
    logic             accept;
    logic             rotate;

    assign req    = '{data: in_data, amt: in_amt};
    assign accept = in_valid && in_ready;
    assign rotate = (state == SHIFT);

    // in_ready is pulled low during reset so nothing can be accepted on the
    // release edge.
`ifdef ROTR_BACK2BACK_EN
    assign in_ready = reset && ((state == IDLE) || ((state == DONE) && out_ready));
`else
    assign in_ready = reset && (state == IDLE);
`endif

    // Shift register: bit i takes bit i+1, the top bit takes bit 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        localparam int NXT = (i + 1) % WIDTH;
        rotr_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .load   (accept),
            .shift  (rotate),
            .ld_bit (req.data[i]),
            .sh_bit (sr[NXT]),
            .q      (sr[i])
        );
    end

    assign out_data = sr;

    // Control FSM with registered busy / out_valid. A zero amount skips
    // SHIFT and lands straight in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        remaining <= req.amt;
                        if (req.amt != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // accept can only be true here in back-to-back builds.
                    if (accept) begin
                        remaining <= req.amt;
                        if (req.amt != '0) begin
                            state     <= SHIFT;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rotr_unit.sv
// ---------------------------------------------------------------------------
// tb_rotr_unit
//   Directed bench for rotr_unit (WIDTH=8). The driver pushes the hand-computed
//   result into a queue when a word is accepted; a monitor pops and compares
//   whenever a result is transferred. Latency, busy length, backpressure hold
//   and reset behaviour are checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_rotr_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    int         errs = 0;
    int         checks = 0;
    logic [7:0] expq[$];

    rotr_unit #(.WIDTH(8), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, when inputs driven
    // at the falling edge are settled and the next rising edge is far away.
    always begin
        @(negedge clk);
        #2;
        if (reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e});
            end
        end
    end

    // Drive a request at the current falling edge and wait for it to be taken.
    // waited = number of extra cycles the request sat before acceptance.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [7:0] e,
                        input bit push, output int waited);
        bit ok;
        ok       = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        if (ok && push) expq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // After an accept edge, count edges until out_valid and busy cycles seen.
    task automatic wait_result(input logic [2:0] a, input string tag);
        int  n;
        int  bc;
        bit  ok;
        n  = 0;
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (busy) bc++;
            n++;
        end
        if (!ok) chk({tag, "_result_timeout"}, 32'd0, 32'd1);
        chk({tag, "_latency"}, n, {29'd0, a});
        chk({tag, "_busy_cycles"}, bc, {29'd0, a});
    endtask

    task automatic txn(input logic [7:0] d, input logic [2:0] a, input logic [7:0] e,
                       input string tag);
        int w;
        send(d, a, e, 1'b1, w);
        wait_result(a, tag);
        @(negedge clk);
    endtask

    initial begin
        int w;

        // Reset held with a request pending: nothing may be taken.
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_amt   = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Main function.
        txn(8'h67, 3'd1, 8'hB3, "inv");
        txn(8'hA5, 3'd0, 8'hA5, "zero");
        txn(8'h01, 3'd7, 8'h02, "max");
        txn(8'hC3, 3'd2, 8'hF0, "amt2");
        txn(8'h12, 3'd3, 8'h42, "amt3");

        // Backpressure: result held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        send(8'h67, 3'd1, 8'hB3, 1'b1, w);
        wait_result(3'd1, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", {24'd0, out_data}, 32'hB3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // Release with a new request pending.
        out_ready = 1'b1;
        send(8'h80, 3'd1, 8'h40, 1'b1, w);
`ifdef ROTR_BACK2BACK_EN
        chk("b2b_accept_wait", w, 32'd0);
`else
        chk("b2b_accept_wait", w, 32'd1);
`endif
        wait_result(3'd1, "b2b");
        @(negedge clk);

        // Reset in the middle of a rotation.
        send(8'hF0, 3'd5, 8'h00, 1'b0, w);
        @(negedge clk);
        chk("mid_busy_1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("mid_busy_2", {31'd0, busy}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn(8'h0F, 3'd4, 8'hF0, "after_rst");

        // Let the monitor drain the last result.
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rotr_unit.md
# rotr_unit

Multi-cycle right-rotator that undoes the left-rotate register stage: it accepts a word and a rotate amount over a valid/ready handshake, rotates right one bit per clock, and presents the result on a second valid/ready handshake. It sits downstream of the rotate-left register in the datapath and restores the original bit order. One rotation per cycle keeps the hardware to a single shift register plus a counter.

## Interface
- `WIDTH`, 8: data width; power of two, ≥ 2.
- `CNT_W`, 3: amount/counter width; must equal clog2(WIDTH).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- `in_valid`  in  1  input word and amount valid.
- `in_ready`  out  1  block can accept input.
- `in_data`  in  WIDTH  word to rotate.
- `in_amt`  in  CNT_W  right-rotate amount, 0..WIDTH-1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  WIDTH  rotated word.
- `busy`  out  1  high while in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE. Registers: state, `sr[WIDTH]`, `remaining[CNT_W]`.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: `sr`<=`in_data`, `remaining`<=`in_amt`; next state is SHIFT if `in_amt`≠0, else DONE.
- SHIFT: each edge `sr`<={`sr[0]`, `sr[WIDTH-1:1]`}, `remaining`<=`remaining`-1. On the edge where `remaining`==1, next state is DONE. Inputs are ignored.
- DONE: `out_valid`=1, `out_data`=`sr`, both held stable until `out_ready`=1. On `out_valid && out_ready`, next state is IDLE, subject to Configuration.
- `in_ready` is combinational from state. It is forced to 0 while `reset` is low.
- `out_data` is `sr`, registered. It is only meaningful while `out_valid`=1.
- `in_amt` is never ≥ WIDTH by construction. No modulo logic is required.

## Timing
- Reset values: state=IDLE, `sr`=0, `remaining`=0, `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=0 while `reset` is low.
- `in_ready`=1 from the first cycle after `reset` deasserts.
- Latency: input accepted at edge k, then `out_valid` rises after edge k+`in_amt`. For `in_amt`=0 this is the next cycle.
- `busy` is high for exactly `in_amt` cycles.
- Backpressure: DONE is held indefinitely while `out_ready`=0. `out_data` must not change during the hold.
- `out_ready` outside DONE has no effect.
- Reset mid-SHIFT or mid-DONE: all outputs go to their reset values asynchronously and any in-flight word is discarded. After deassertion the next accept proceeds cleanly.
- Without the macro, minimum spacing between accepts is `in_amt`+2 cycles, because of one IDLE bubble.

## Configuration
- `ROTR_BACK2BACK_EN`:
  - Defined: in DONE, `in_ready`=`out_ready`. A transfer out and a transfer in can occur on the same edge; the new word loads and the state goes directly to SHIFT, or stays in DONE for amt=0. Accept spacing becomes `in_amt`+1 cycles.
  - Undefined: `in_ready`=1 only in IDLE. A transfer out always passes through IDLE for one cycle.

## Test plan
- Reset: hold `reset`=0 with `in_valid`=1. Required: `in_ready`=0, `out_valid`=0, `out_data`=0x00, nothing accepted. After release, `in_ready`=1 next cycle.
- Inverse check: `in_data`=0x67 (0b01100111), `in_amt`=1, accepted at edge k, `out_ready`=1. Required: `out_valid`=1 after edge k+1, `out_data`=0xB3; `busy` high for 1 cycle.
- Zero amount: `in_data`=0xA5, `in_amt`=0. Required: `out_valid`=1 one cycle after accept, `out_data`=0xA5, `busy` never high.
- Maximum amount: `in_data`=0x01, `in_amt`=7. Required: `busy` high for 7 cycles, `out_valid` after edge k+7, `out_data`=0x02.
- Backpressure and back-to-back: result 0xB3 pending with `out_ready`=0 for 5 cycles. Required: `out_valid`/`out_data` stable and `in_ready`=0 throughout. Then raise `out_ready` with a new input pending (0x80, amt=1):
  - With `ROTR_BACK2BACK_EN`: accepted on the same edge, result 0x40.
  - Without the macro: accepted one cycle later, same result.
- Mid-operation reset: `in_data`=0xF0, `in_amt`=5, assert `reset`=0 after 2 SHIFT cycles. Required: `busy`/`out_valid`/`out_data` go to 0 immediately. After release, a new input 0x0F with amt=4 produces 0xF0.
